// File: rtl/sastavljac_uzorka_pkg.sv
// ---------------------------------------------------------------------------
// sastavljac_uzorka_pkg
//
// Shared definitions for the neuron-layer front end. It holds the sample
// geometry (features per sample, feature width), the sign-magnitude negative
// zero constant, the sample-counter width and the assembler state encoding.
// ---------------------------------------------------------------------------
package sastavljac_uzorka_pkg;

    // Number of features that make up one sample for the neuron layer.
    localparam int BROJ_ZNACAJKI = 60;

    // Feature width. Bit 15 is the sign and bits 14:0 are the magnitude.
    localparam int SIRINA = 16;

    // Sign-magnitude negative zero. It is folded to +0 before storage so the
    // neuron layer only ever sees one encoding of zero.
    localparam logic [15:0] NEGATIVNA_NULA = 16'h8000;

    // Width of the delivered-sample counter. The counter wraps at its maximum value.
    localparam int SIRINA_BROJACA = 16;

    // Assembler states: filling slots, or holding a complete sample.
    typedef enum logic {
        PUNJENJE = 1'b0,
        PUNO     = 1'b1
    } stanje_e;

endpackage

// File: rtl/sastavljac_uzorka.sv
// ---------------------------------------------------------------------------
// sastavljac_uzorka
//
// Collects BROJ_ZNACAJKI sign-magnitude features, arriving one at a time,
// into one packed sample vector. The block then presents that vector to the
// neuron layer with a valid/ready handshake.
//
// Ports
//   clk            : single clock. All state updates on the rising edge.
//   rst            : asynchronous, active-high reset.
//   znacajka       : incoming feature, SIRINA bits, sign-magnitude.
//   znacajka_valid : the feature is present.
//   znacajka_ready : the block accepts a feature. This is high only while filling.
//   ponisti        : synchronous abort of a partially filled sample.
//   uzorak         : packed sample. Slot k occupies bits [SIRINA*k +: SIRINA].
//   uzorak_valid   : uzorak holds a complete sample.
//   uzorak_ready   : the downstream consumer takes the sample.
//   broj_uzoraka   : count of delivered samples. It wraps at 16 bits.
// ---------------------------------------------------------------------------
module sastavljac_uzorka #(
    parameter int BROJ_ZNACAJKI = sastavljac_uzorka_pkg::BROJ_ZNACAJKI,
    parameter int SIRINA        = sastavljac_uzorka_pkg::SIRINA
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SIRINA-1:0]                 znacajka,
    input  logic                              znacajka_valid,
    output logic                              znacajka_ready,
    input  logic                              ponisti,
    output logic [BROJ_ZNACAJKI*SIRINA-1:0]   uzorak,
    output logic                              uzorak_valid,
    input  logic                              uzorak_ready,
    output logic [15:0]                       broj_uzoraka
);

    import sastavljac_uzorka_pkg::*;

    // The index must be at least one bit wide, even for a one-feature sample.
    localparam int IW = (BROJ_ZNACAJKI > 1) ? $clog2(BROJ_ZNACAJKI) : 1;
    localparam logic [IW-1:0] ZADNJI_INDEKS = IW'(BROJ_ZNACAJKI - 1);

    // Negative zero is the sign bit alone. The package constant is aligned to
    // the top of the feature word, so it still matches if features are widened.
    localparam logic [SIRINA-1:0] NEG_NULA = SIRINA'(NEGATIVNA_NULA) << (SIRINA - 16);

    stanje_e                              stanje_q, stanje_d;
    logic [IW-1:0]                        indeks_q, indeks_d;
    logic [BROJ_ZNACAJKI-1:0][SIRINA-1:0] uzorak_q, uzorak_d;
    logic [SIRINA_BROJACA-1:0]            broj_q, broj_d;
    logic                                 uzorak_valid_q, uzorak_valid_d;
    logic                                 znacajka_ready_q, znacajka_ready_d;
    logic [SIRINA-1:0]                    upisna_vrijednost;

    // Fold negative zero to positive zero. Every other value is stored as it arrives.
    always_comb begin
        upisna_vrijednost = znacajka;
        if (znacajka == NEG_NULA) begin
            upisna_vrijednost = '0;
        end
    end

    // Next-state logic. While filling, an abort takes priority over a feature
    // presented in the same cycle. Slots are not cleared on abort: every slot
    // is rewritten before the next sample can complete. While full, only the
    // downstream handshake matters. Abort and new features are ignored until
    // the sample leaves, and filling resumes one cycle later.
    always_comb begin
        stanje_d = stanje_q;
        indeks_d = indeks_q;
        uzorak_d = uzorak_q;
        broj_d   = broj_q;
        unique case (stanje_q)
            PUNJENJE: begin
                if (ponisti) begin
                    indeks_d = '0;
                end else if (znacajka_valid) begin
                    uzorak_d[indeks_q] = upisna_vrijednost;
                    if (indeks_q == ZADNJI_INDEKS) begin
                        indeks_d = '0;
                        stanje_d = PUNO;
                    end else begin
                        indeks_d = indeks_q + 1'b1;
                    end
                end
            end
            PUNO: begin
                if (uzorak_ready) begin
                    stanje_d = PUNJENJE;
                    broj_d   = broj_q + 1'b1;
                end
            end
            default: begin
                stanje_d = PUNJENJE;
                indeks_d = '0;
            end
        endcase
    end

    // Both handshake outputs are registered copies of the next state. They
    // therefore always agree with the state register, and reset to the filling view.
    always_comb begin
        uzorak_valid_d   = (stanje_d == PUNO);
        znacajka_ready_d = (stanje_d == PUNJENJE);
    end

    // State register. Reset discards any partial or complete sample without
    // counting it as delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stanje_q         <= PUNJENJE;
            indeks_q         <= '0;
            uzorak_q         <= '0;
            broj_q           <= '0;
            uzorak_valid_q   <= 1'b0;
            znacajka_ready_q <= 1'b1;
        end else begin
            stanje_q         <= stanje_d;
            indeks_q         <= indeks_d;
            uzorak_q         <= uzorak_d;
            broj_q           <= broj_d;
            uzorak_valid_q   <= uzorak_valid_d;
            znacajka_ready_q <= znacajka_ready_d;
        end
    end

    assign uzorak         = uzorak_q;
    assign uzorak_valid   = uzorak_valid_q;
    assign znacajka_ready = znacajka_ready_q;
    assign broj_uzoraka   = broj_q;

endmodule

// File: tb/tb_sastavljac_uzorka.sv
// ---------------------------------------------------------------------------
// tb_sastavljac_uzorka
//
// Drives the sample assembler with directed and randomized feature streams.
// A reference model, kept as a queue of accepted features, predicts each
// completed sample and pushes it to a scoreboard. A separate monitor pops the
// scoreboard whenever the design hands a sample downstream.
// ---------------------------------------------------------------------------
module tb_sastavljac_uzorka;

    localparam int N  = 60;
    localparam int W  = 16;
    localparam int BW = N * W;

    logic          clk;
    logic          rst;
    logic [W-1:0]  znacajka;
    logic          znacajka_valid;
    logic          znacajka_ready;
    logic          ponisti;
    logic [BW-1:0] uzorak;
    logic          uzorak_valid;
    logic          uzorak_ready;
    logic [15:0]   broj_uzoraka;

    int errors = 0;
    int checks = 0;

    sastavljac_uzorka #(.BROJ_ZNACAJKI(N), .SIRINA(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .znacajka       (znacajka),
        .znacajka_valid (znacajka_valid),
        .znacajka_ready (znacajka_ready),
        .ponisti        (ponisti),
        .uzorak         (uzorak),
        .uzorak_valid   (uzorak_valid),
        .uzorak_ready   (uzorak_ready),
        .broj_uzoraka   (broj_uzoraka)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the features gathered so far, whether a finished
    // sample is waiting, and how many samples have been delivered.
    typedef struct {
        logic [BW-1:0] vec;
        logic [15:0]   cnt;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] m_cur[$];
    bit          m_full  = 1'b0;
    logic [15:0] m_count = '0;
    int          m_deliv = 0;

    // Generic comparison. Every failure prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sample-vector comparison. On failure it reports the first differing slot.
    task automatic checkVector(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < N; k++) begin
                if (act[k*W +: W] !== exp[k*W +: W]) begin
                    $display("[TB] FAIL %s: slot %0d got %h, expected %h", name, k, act[k*W +: W], exp[k*W +: W]);
                    break;
                end
            end
        end
    endtask

    // Advances the behavioural model by one clock edge with the given inputs.
    task automatic modelStep(input logic [15:0] d, input bit v, input bit p, input bit r);
        sb_t e;
        if (!m_full) begin
            if (p) begin
                m_cur.delete();
            end else if (v) begin
                m_cur.push_back((d == 16'h8000) ? 16'h0000 : d);
                if (m_cur.size() == N) begin
                    e.vec = '0;
                    for (int k = 0; k < N; k++) e.vec[k*W +: W] = m_cur[k];
                    e.cnt = m_count;
                    sb.push_back(e);
                    m_cur.delete();
                    m_full = 1'b1;
                end
            end
        end else if (r) begin
            m_full  = 1'b0;
            m_count = m_count + 16'd1;
            m_deliv++;
        end
    endtask

    // Drives one cycle of inputs and updates the model. After the edge it
    // checks both handshake outputs against the model.
    task automatic applyStimulus(input logic [15:0] d, input bit v, input bit p, input bit r);
        znacajka       = d;
        znacajka_valid = v;
        ponisti        = p;
        uzorak_ready   = r;
        modelStep(d, v, p, r);
        @(posedge clk);
        #1;
        checkOutput("znacajka_ready", {31'd0, znacajka_ready}, {31'd0, !m_full});
        checkOutput("uzorak_valid", {31'd0, uzorak_valid}, {31'd0, m_full});
    endtask

    // Asserts reset mid-cycle and checks that the outputs clear before any clock edge.
    task automatic doReset();
        rst            = 1'b1;
        znacajka_valid = 1'b0;
        ponisti        = 1'b0;
        uzorak_ready   = 1'b0;
        #1;
        checkOutput("rst_uzorak_valid", {31'd0, uzorak_valid}, 32'd0);
        checkVector("rst_uzorak", uzorak, '0);
        checkOutput("rst_broj", {16'd0, broj_uzoraka}, 32'd0);
        checkOutput("rst_znacajka_ready", {31'd0, znacajka_ready}, 32'd1);
        m_cur.delete();
        sb.delete();
        m_full  = 1'b0;
        m_count = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Random traffic until the requested number of further deliveries has
    // happened. The loop has a cycle budget, and running out of it counts as a failure.
    task automatic runRandom(input int samples);
        int target = m_deliv + samples;
        int cyc = 0;
        logic [15:0] d;
        while (m_deliv < target && cyc < 20000) begin
            d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) d = 16'h8000;
            applyStimulus(d, $urandom_range(0, 2) != 0, $urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1);
            cyc++;
        end
        checkOutput("random_budget", (m_deliv >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: on every downstream handshake it pops the oldest expected sample.
    // On the following cycle it confirms that the delivery count has advanced.
    bit          pend = 1'b0;
    logic [15:0] pend_cnt;
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                checkOutput("broj_after_delivery", {16'd0, broj_uzoraka}, {16'd0, pend_cnt});
                pend = 1'b0;
            end
            if (uzorak_valid && uzorak_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_sample: got uzorak_valid=1, expected no pending sample");
                end else begin
                    e = sb.pop_front();
                    checkVector("uzorak_delivered", uzorak, e.vec);
                    checkOutput("broj_before_delivery", {16'd0, broj_uzoraka}, {16'd0, e.cnt});
                    pend     = 1'b1;
                    pend_cnt = e.cnt + 16'd1;
                end
            end
        end
    end

    // Watchdog: if the run never finishes, report it and stop.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BW-1:0] held;
        logic [15:0]   first_new;

        rst            = 1'b1;
        znacajka       = '0;
        znacajka_valid = 1'b0;
        ponisti        = 1'b0;
        uzorak_ready   = 1'b0;
        #2;
        checkOutput("reset_ready", {31'd0, znacajka_ready}, 32'd1);
        checkOutput("reset_valid", {31'd0, uzorak_valid}, 32'd0);
        checkVector("reset_uzorak", uzorak, '0);
        checkOutput("reset_broj", {16'd0, broj_uzoraka}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic fill");
        for (int k = 0; k < N; k++) applyStimulus(16'h0100 + 16'(k), 1'b1, 1'b0, 1'b0);
        checkOutput("fill_slot0", {16'd0, uzorak[15:0]}, 32'h0100);
        checkOutput("fill_slot59", {16'd0, uzorak[959:944]}, 32'h013B);
        checkOutput("fill_ready_low", {31'd0, znacajka_ready}, 32'd0);

        $display("[TB] backpressure");
        held = sb[0].vec;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(16'h7777, i[0], 1'b0, 1'b0);
            checkVector("hold_uzorak", uzorak, held);
        end
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("first_delivery_broj", {16'd0, broj_uzoraka}, 32'd1);

        $display("[TB] abort");
        for (int k = 0; k < 25; k++) applyStimulus(16'($urandom), 1'b1, 1'b0, $urandom_range(0, 1) == 1);
        applyStimulus(16'hAAAA, 1'b1, 1'b1, 1'b0);
        first_new = 16'h1234;
        applyStimulus(first_new, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < N; k++) applyStimulus(16'($urandom) & 16'h7FFF, 1'b1, 1'b0, 1'b0);
        checkOutput("abort_slot0", {16'd0, uzorak[15:0]}, {16'd0, first_new});
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);

        $display("[TB] negative zero");
        for (int k = 0; k < N; k++) begin
            if (k == 3)      applyStimulus(16'h8000, 1'b1, 1'b0, 1'b0);
            else if (k == 4) applyStimulus(16'h8001, 1'b1, 1'b0, 1'b0);
            else             applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
        end
        checkOutput("negzero_slot3", {16'd0, uzorak[63:48]}, 32'h0000);
        checkOutput("negzero_slot4", {16'd0, uzorak[79:64]}, 32'h8001);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset mid-fill and while full");
        for (int k = 0; k < 40; k++) applyStimulus(16'($urandom) | 16'h0001, 1'b1, 1'b0, 1'b0);
        doReset();
        for (int k = 0; k < N; k++) applyStimulus(16'($urandom) | 16'h0001, 1'b1, 1'b0, 1'b0);
        doReset();

        $display("[TB] counter wrap with random gaps");
        force dut.broj_q = 16'hFFFD;
        #1;
        release dut.broj_q;
        m_count = 16'hFFFD;
        runRandom(6);
        checkOutput("wrap_broj", {16'd0, broj_uzoraka}, 32'h0003);

        $display("[TB] random traffic");
        runRandom(10);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
